// File: rtl/mem_pkg.sv
// =====================================================================
// mem_pkg: memory-stage opcodes, LSU states and opcode decode helpers. Rev 1.0
// =====================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [4:0] {
    MEM_NONE = 5'd0,
    LB, LH, LW, LD, LBU, LHU, LWU,
    SB, SH, SW, SD,
    FLW, FLD, FSW, FSD
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } lsu_state_e;

  // Access size as log2(bytes)
  function automatic logic [1:0] op_size(mem_op_e op);
    case (op)
      LH, LHU, SH:            return 2'd1;
      LW, LWU, SW, FLW, FSW:  return 2'd2;
      LD, SD, FLD, FSD:       return 2'd3;
      default:                return 2'd0;
    endcase
  endfunction

  function automatic logic op_is_store(mem_op_e op);
    return (op == SB) || (op == SH) || (op == SW) || (op == SD) ||
           (op == FSW) || (op == FSD);
  endfunction

  function automatic logic op_is_signed(mem_op_e op);
    return (op == LB) || (op == LH) || (op == LW);
  endfunction

  function automatic logic op_is_mem(mem_op_e op);
    return (op != MEM_NONE) && (op <= FSD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// =====================================================================
// lsu_load_align: lane-steer a load word, then sign/zero-extend or NaN-box. Rev 1.0
// =====================================================================
`default_nettype none

module lsu_load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]            rdata,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  mem_op_e                    op,
  output logic [XLEN-1:0]            result
);

  localparam int IDX_W = $clog2(XLEN);

  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  low_mask;
  logic [6:0]       nbits;
  logic [IDX_W-1:0] sign_idx;
  logic             sign;

  always_comb begin
    shifted  = rdata >> {offset, 3'b000};
    nbits    = 7'd8 << op_size(op);
    low_mask = ~({XLEN{1'b1}} << nbits);
    sign_idx = IDX_W'(nbits - 7'd1);
    sign     = op_is_signed(op) & shifted[sign_idx];
    result   = (shifted & low_mask) | (sign ? ~low_mask : '0);
    // Single-precision values in the FP file are boxed with all-ones above bit 31
    if (op == FLW) begin
      result = (shifted & low_mask) | ~low_mask;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// =====================================================================
// mem_stage_lsu: RV64 memory stage; aligned loads/stores over req/gnt/rvalid. Rev 1.0
// =====================================================================
`default_nettype none

module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 48,
  parameter int RIDX_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_ex,
  output logic                ready_ex,
  input  logic [4:0]          type_op_mem_ex,
  input  logic [ADDR_W-1:0]   mem_addr_ex,
  input  logic [XLEN-1:0]     store_data_ex,
  input  logic [XLEN-1:0]     op_ex,
  input  logic [RIDX_W-1:0]   rd_ex,
  input  logic                we_rd_ex,
  input  logic                reg_type_ex,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                valid_mem,
  output logic [XLEN-1:0]     op_mem,
  output logic [RIDX_W-1:0]   rd_mem,
  output logic                we_rd_mem,
  output logic                reg_type_mem,
  output logic                trap_mem,
  output logic                trap_store_mem
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BE_W - 1);

  lsu_state_e          state_q, state_d;
  mem_op_e             op_q, op_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [RIDX_W-1:0]   rd_q, rd_d;
  logic                we_q, we_d, rtype_q, rtype_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;

  logic                valid_q, valid_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [RIDX_W-1:0]   rd_mem_q, rd_mem_d;
  logic                we_mem_q, we_mem_d, rtype_mem_q, rtype_mem_d;
  logic                trap_q, trap_d, trap_st_q, trap_st_d;

  mem_op_e             op_in;
  logic [OFF_W-1:0]    off_in;
  logic [3:0]          bytes_in;
  logic                misaligned;
  logic [BE_W-1:0]     be_mask;
  logic [XLEN-1:0]     load_result;

  assign op_in      = mem_op_e'(type_op_mem_ex);
  assign off_in     = mem_addr_ex[OFF_W-1:0];
  assign bytes_in   = 4'd1 << op_size(op_in);
  assign misaligned = (off_in & OFF_W'(bytes_in - 4'd1)) != '0;
  assign be_mask    = ~({BE_W{1'b1}} << bytes_in);

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (mem_rdata),
    .offset (off_q),
    .op     (op_q),
    .result (load_result)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    rd_d        = rd_q;
    we_d        = we_q;
    rtype_d     = rtype_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    valid_d     = 1'b0;
    result_d    = result_q;
    rd_mem_d    = rd_mem_q;
    we_mem_d    = we_mem_q;
    rtype_mem_d = rtype_mem_q;
    trap_d      = trap_q;
    trap_st_d   = trap_st_q;
    case (state_q)
      IDLE: if (valid_ex) begin
        if (!op_is_mem(op_in)) begin
          // Unknown opcodes pass through but never write a register
          valid_d     = 1'b1;
          result_d    = op_ex;
          rd_mem_d    = rd_ex;
          we_mem_d    = we_rd_ex && (op_in == MEM_NONE);
          rtype_mem_d = reg_type_ex;
          trap_d      = 1'b0;
          trap_st_d   = 1'b0;
        end else if (misaligned) begin
          valid_d     = 1'b1;
          result_d    = '0;
          rd_mem_d    = rd_ex;
          we_mem_d    = 1'b0;
          rtype_mem_d = reg_type_ex;
          trap_d      = 1'b1;
          trap_st_d   = op_is_store(op_in);
        end else begin
          state_d = REQ;
          op_d    = op_in;
          off_d   = off_in;
          rd_d    = rd_ex;
          we_d    = we_rd_ex;
          rtype_d = reg_type_ex;
          addr_d  = mem_addr_ex & ALIGN_MASK;
          be_d    = be_mask << off_in;
          wdata_d = store_data_ex << {off_in, 3'b000};
        end
      end
      REQ: if (mem_gnt) begin
        if (op_is_store(op_q)) begin
          state_d     = DONE;
          valid_d     = 1'b1;
          result_d    = '0;
          rd_mem_d    = rd_q;
          we_mem_d    = 1'b0;
          rtype_mem_d = rtype_q;
          trap_d      = 1'b0;
          trap_st_d   = 1'b0;
        end else begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: if (mem_rvalid) begin
        state_d     = IDLE;
        valid_d     = 1'b1;
        result_d    = load_result;
        rd_mem_d    = rd_q;
        we_mem_d    = we_q;
        rtype_mem_d = rtype_q;
        trap_d      = 1'b0;
        trap_st_d   = 1'b0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= MEM_NONE;
      off_q       <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      rtype_q     <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      rd_mem_q    <= '0;
      we_mem_q    <= 1'b0;
      rtype_mem_q <= 1'b0;
      trap_q      <= 1'b0;
      trap_st_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      rtype_q     <= rtype_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      rd_mem_q    <= rd_mem_d;
      we_mem_q    <= we_mem_d;
      rtype_mem_q <= rtype_mem_d;
      trap_q      <= trap_d;
      trap_st_q   <= trap_st_d;
    end
  end

  assign ready_ex       = (state_q == IDLE);
  assign mem_req        = (state_q == REQ);
  assign mem_we         = mem_req && op_is_store(op_q);
  assign mem_addr       = addr_q;
  assign mem_be         = be_q;
  assign mem_wdata      = wdata_q;
  assign valid_mem      = valid_q;
  assign op_mem         = result_q;
  assign rd_mem         = rd_mem_q;
  assign we_rd_mem      = we_mem_q;
  assign reg_type_mem   = rtype_mem_q;
  assign trap_mem       = trap_q;
  assign trap_store_mem = trap_st_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// =====================================================================
// tb_mem_stage_lsu: directed plus randomized bench for mem_stage_lsu. Rev 1.0
// =====================================================================
`default_nettype none

module tb_mem_stage_lsu;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_ex = 1'b0;
  logic        ready_ex;
  logic [4:0]  type_op_mem_ex = '0;
  logic [47:0] mem_addr_ex = '0;
  logic [63:0] store_data_ex = '0;
  logic [63:0] op_ex = '0;
  logic [4:0]  rd_ex = '0;
  logic        we_rd_ex = 1'b0;
  logic        reg_type_ex = 1'b0;
  logic        mem_req, mem_we;
  logic [47:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        valid_mem;
  logic [63:0] op_mem;
  logic [4:0]  rd_mem;
  logic        we_rd_mem, reg_type_mem, trap_mem, trap_store_mem;

  mem_stage_lsu #(.XLEN(64), .ADDR_W(48), .RIDX_W(5)) dut (
    .clk(clk), .reset(rst), .valid_ex(valid_ex), .ready_ex(ready_ex),
    .type_op_mem_ex(type_op_mem_ex), .mem_addr_ex(mem_addr_ex),
    .store_data_ex(store_data_ex), .op_ex(op_ex), .rd_ex(rd_ex),
    .we_rd_ex(we_rd_ex), .reg_type_ex(reg_type_ex),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .valid_mem(valid_mem), .op_mem(op_mem),
    .rd_mem(rd_mem), .we_rd_mem(we_rd_mem), .reg_type_mem(reg_type_mem),
    .trap_mem(trap_mem), .trap_store_mem(trap_store_mem)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit started = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] op_mem;
    bit          chk_data;
    logic [4:0]  rd;
    logic        we, rt, trap, tst;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sizes, store class and load results from the ISA rules
  function automatic int bytes_of(logic [4:0] op);
    case (op)
      LB, LBU, SB:           return 1;
      LH, LHU, SH:           return 2;
      LW, LWU, SW, FLW, FSW: return 4;
      LD, SD, FLD, FSD:      return 8;
      default:               return 0;
    endcase
  endfunction

  function automatic bit is_store(logic [4:0] op);
    return op inside {SB, SH, SW, SD, FSW, FSD};
  endfunction

  function automatic logic [63:0] model_load(logic [4:0] op, logic [63:0] rdata, int off);
    logic [63:0] s;
    s = rdata >> (8 * off);
    case (op)
      LB:       return 64'($signed(s[7:0]));
      LH:       return 64'($signed(s[15:0]));
      LW:       return 64'($signed(s[31:0]));
      LBU:      return 64'(s[7:0]);
      LHU:      return 64'(s[15:0]);
      LWU:      return 64'(s[31:0]);
      FLW:      return {32'hFFFF_FFFF, s[31:0]};
      default:  return s;
    endcase
  endfunction

  function automatic logic [7:0] model_be(int nb, int off);
    return 8'(((1 << nb) - 1) << off);
  endfunction

  // One compare process: valid_mem must pulse exactly on predicted cycles
  always @(negedge clk) begin
    if (!rst && started) begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        chk("missed_result_cycle", 64'(cyc), 64'(expq[0].cyc));
        void'(expq.pop_front());
      end
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        exp_t e;
        e = expq.pop_front();
        chk("valid_mem", valid_mem, 1'b1);
        chk("trap_mem", trap_mem, e.trap);
        chk("we_rd_mem", we_rd_mem, e.we);
        if (e.trap) chk("trap_store_mem", trap_store_mem, e.tst);
        if (e.chk_data) begin
          chk("op_mem", op_mem, e.op_mem);
          chk("rd_mem", rd_mem, e.rd);
          chk("reg_type_mem", reg_type_mem, e.rt);
        end
      end else begin
        chk("valid_mem_idle", valid_mem, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [4:0] op, input logic [47:0] addr,
                         input logic [63:0] sd, input logic [63:0] opx,
                         input logic [4:0] rd, input logic we, input logic rt,
                         input int gdel, input int rdel, input logic [63:0] rdata);
    int   nb, off, n;
    bit   mis;
    exp_t e;
    nb  = bytes_of(op);
    off = int'(addr[2:0]);
    mis = (nb != 0) && ((off % nb) != 0);
    e.rd = rd; e.rt = rt; e.trap = 1'b0; e.tst = 1'b0; e.chk_data = 1'b1;
    e.op_mem = opx; e.we = we && (op == 5'd0);
    chk("ready_before_accept", ready_ex, 1'b1);
    valid_ex = 1'b1; type_op_mem_ex = op; mem_addr_ex = addr; store_data_ex = sd;
    op_ex = opx; rd_ex = rd; we_rd_ex = we; reg_type_ex = rt;
    tick();
    valid_ex = 1'b0;
    type_op_mem_ex = 5'($urandom_range(0, 31));
    mem_addr_ex = 48'({$urandom(), $urandom()});
    if (nb == 0 || mis) begin
      if (mis) begin
        e.trap = 1'b1; e.tst = is_store(op); e.we = 1'b0; e.chk_data = 1'b0;
      end
      e.cyc = cyc;
      expq.push_back(e);
      chk("no_req_nonaligned", mem_req, 1'b0);
    end else begin
      for (int k = 0; k <= gdel; k++) begin
        chk("mem_req_held", mem_req, 1'b1);
        chk("mem_we", mem_we, is_store(op));
        chk("mem_addr", mem_addr, addr & ~48'h7);
        chk("mem_be", mem_be, model_be(nb, off));
        chk("mem_wdata", mem_wdata, sd << (8 * off));
        mem_gnt    = (k == gdel);
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = {$urandom(), $urandom()};
        tick();
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("req_dropped_after_gnt", mem_req, 1'b0);
      if (is_store(op)) begin
        e.we = 1'b0; e.chk_data = 1'b0; e.cyc = cyc;
        expq.push_back(e);
      end else begin
        for (int k = 0; k < rdel; k++) begin
          chk("no_req_wait_r", mem_req, 1'b0);
          tick();
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = {$urandom(), $urandom()};
        e.op_mem = model_load(op, rdata, off); e.we = we; e.cyc = cyc;
        expq.push_back(e);
      end
    end
    n = 0;
    while (!ready_ex && n < 4) begin
      tick();
      n++;
    end
    chk("ready_after_txn", ready_ex, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  op;
    logic [47:0] addr;
    int          nb, off;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_ex, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_valid", valid_mem, 1'b0);
    chk("rst_op_mem", op_mem, 64'h0);
    chk("rst_trap", trap_mem, 1'b0);
    rst = 1'b0;
    started = 1'b1;
    tick();

    chk("pin_lb",   model_load(LB,  64'h0000_0000_8000_0000, 3), 64'hFFFF_FFFF_FFFF_FF80);
    chk("pin_lbu",  model_load(LBU, 64'h0000_0000_8000_0000, 3), 64'h80);
    chk("pin_flw",  model_load(FLW, 64'h3F80_0000_DEAD_BEEF, 4), 64'hFFFF_FFFF_3F80_0000);
    chk("pin_be",   model_be(2, 6), 8'hC0);
    chk("pin_wdat", 64'hABCD << (8 * 6), 64'hABCD_0000_0000_0000);

    run_txn(MEM_NONE, 48'h1000, 64'h0, 64'h1234, 5'd7, 1'b1, 1'b0, 0, 0, 64'h0);
    run_txn(SH,  48'h1006, 64'hABCD, 64'h0, 5'd3, 1'b1, 1'b0, 3, 0, 64'h0);
    run_txn(LB,  48'h1003, 64'h0, 64'h0, 5'd9, 1'b1, 1'b0, 0, 0, 64'h0000_0000_8000_0000);
    run_txn(LBU, 48'h1003, 64'h0, 64'h0, 5'd9, 1'b1, 1'b0, 1, 1, 64'h0000_0000_8000_0000);
    run_txn(FLW, 48'h1004, 64'h0, 64'h0, 5'd2, 1'b1, 1'b1, 0, 0, 64'h3F80_0000_DEAD_BEEF);
    run_txn(LW,  48'h1002, 64'h0, 64'h0, 5'd4, 1'b1, 1'b0, 0, 0, 64'h0);
    run_txn(SD,  48'h1004, 64'h55, 64'h0, 5'd4, 1'b1, 1'b0, 0, 0, 64'h0);
    run_txn(5'd20, 48'h1000, 64'h0, 64'hCAFE, 5'd6, 1'b1, 1'b0, 0, 0, 64'h0);

    // Reset while waiting for load data, then a stale rvalid after release
    valid_ex = 1'b1; type_op_mem_ex = LD; mem_addr_ex = 48'h2000; rd_ex = 5'd1; we_rd_ex = 1'b1;
    tick();
    valid_ex = 1'b0;
    chk("rst_test_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rst_test_wait_ready", ready_ex, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_mem_req", mem_req, 1'b0);
    chk("async_rst_valid", valid_mem, 1'b0);
    chk("async_rst_ready", ready_ex, 1'b1);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    tick();
    mem_rvalid = 1'b0;
    repeat (2) tick();
    chk("late_rvalid_ready", ready_ex, 1'b1);

    for (int i = 0; i < 250; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      nb = bytes_of(op);
      if (nb > 0 && $urandom_range(0, 1) == 1) off = nb * int'($urandom_range(0, 8 / nb - 1));
      else off = int'($urandom_range(0, 7));
      addr = 48'({$urandom(), $urandom()});
      addr[2:0] = 3'(off);
      run_txn(op, addr, {$urandom(), $urandom()}, {$urandom(), $urandom()},
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), {$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) tick();
    end

    repeat (3) tick();
    chk("expect_queue_drained", 64'(expq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
